add_sub_arbiter: RTL

Round-robin arbiter that shares one `add_sub` datapath among `N_REQ` requesters, such as accumulator lanes or address generators in the CNN accelerator. Each requester presents operands over a valid/ready handshake. At most one request is granted per cycle and driven through a single internal `add_sub` instance. The result, its carry/borrow and the winning requester's index are registered into a single-entry response slot with its own valid/ready handshake.

---
 rtl/add_sub_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/add_sub_arbiter.sv
// Round-robin arbiter sharing one add/sub datapath among N_REQ requesters,
// with a single-entry registered response slot.

module add_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] full;

  // Zero-extended subtract leaves the borrow (a < b) in the top bit.
  always_comb begin
    full   = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    result = full[WIDTH-1:0];
    carry  = full[WIDTH];
  end

endmodule

module add_sub_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ-1:0]       req_sub,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_result,
  output logic                   rsp_carry
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_t;

  slot_t           state, state_d;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] win;
  logic [ID_W-1:0] cand;
  logic            found;
  logic            slot_free;
  logic            xfer;
  logic [WIDTH-1:0] op_a, op_b;
  logic            op_sub;
  logic [WIDTH-1:0] sum;
  logic            sum_carry;

  // Search ptr+1, ptr+2, ... modulo N_REQ; first valid requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((32'(ptr) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign slot_free = (state == EMPTY) || rsp_ready;
  assign req_ready = (rst_n && found && slot_free) ? (N_REQ'(1) << win) : '0;
  assign xfer      = |req_ready;

  assign op_a   = req_a[win*WIDTH +: WIDTH];
  assign op_b   = req_b[win*WIDTH +: WIDTH];
  assign op_sub = req_sub[win];

  add_sub #(.WIDTH(WIDTH)) u_add_sub (
    .a      (op_a),
    .b      (op_b),
    .sub    (op_sub),
    .result (sum),
    .carry  (sum_carry)
  );

  // A transfer overrides a concurrent drain so the slot stays full without a bubble.
  always_comb begin
    state_d = state;
    if (xfer)
      state_d = FULL;
    else if (state == FULL && rsp_ready)
      state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      ptr        <= ID_W'(N_REQ - 1);
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
    end else begin
      state <= state_d;
      if (xfer) begin
        ptr        <= win;
        rsp_id     <= win;
        rsp_result <= sum;
        rsp_carry  <= sum_carry;
      end
    end
  end

  assign rsp_valid = (state == FULL);

endmodule
